wb_arb: RTL and testbench



---
 rtl/wb_arb.sv | 101 ++++++++++
 tb/tb_wb_arb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_arb.sv
// Round-robin writeback arbiter: N execution pipes share one ROB/PRF writeback
// port through a single registered output entry, with an urgent priority class.

module wb_arb_lane (
  input  logic valid,
  input  logic urgent,
  input  logic any_urg,
  output logic cand
);
  // While any urgent request is present, only urgent lanes compete.
  assign cand = valid & (urgent | ~any_urg);
endmodule

module wb_arb #(
  parameter int CONFIG_P_REQ     = 2,
  parameter int CONFIG_PAYLOAD_W = 128
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic [(1<<CONFIG_P_REQ)-1:0]              req_valid,
  input  logic [(1<<CONFIG_P_REQ)-1:0]              req_urgent,
  input  logic [(1<<CONFIG_P_REQ)*CONFIG_PAYLOAD_W-1:0] req_payload,
  output logic [(1<<CONFIG_P_REQ)-1:0]              req_ready,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [CONFIG_PAYLOAD_W-1:0]               out_payload,
  output logic [CONFIG_P_REQ-1:0]                   out_src,
  output logic                                      out_urgent
);
  localparam int N  = 1 << CONFIG_P_REQ;
  localparam int P  = CONFIG_P_REQ;
  localparam int PW = CONFIG_PAYLOAD_W;

  logic [N-1:0][PW-1:0] pl;
  logic [N-1:0]         cand;
  logic [N-1:0]         grant;
  logic [P-1:0]         ptr;
  logic [P-1:0]         grant_idx;
  logic [P-1:0]         idx;
  logic                 grant_any;
  logic                 any_urg;
  logic                 slot_free;
  logic                 accept;

  assign pl      = req_payload;
  assign any_urg = |(req_valid & req_urgent);

  for (genvar i = 0; i < N; i++) begin : g_lane
    wb_arb_lane u_lane (
      .valid  (req_valid[i]),
      .urgent (req_urgent[i]),
      .any_urg(any_urg),
      .cand   (cand[i])
    );
  end

  // Walk offsets from far to near so the nearest candidate at/after ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + P'(k);
      if (cand[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant     = grant_any ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign slot_free = ~out_valid | out_ready;
  assign accept    = grant_any & slot_free & ~flush;
  assign req_ready = accept ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_urgent <= 1'b0;
      out_src    <= '0;
      ptr        <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_urgent <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_urgent <= req_urgent[grant_idx];
      out_src    <= grant_idx;
      ptr        <= grant_idx + P'(1);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      out_urgent <= 1'b0;
    end
  end

  // Payload is a plain load-enabled register; don't-care while out_valid=0.
  always_ff @(posedge clk) begin
    if (accept) out_payload <= pl[grant_idx];
  end
endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: expected entries queued at grant time, checked
// when the registered output presents them.

module tb_wb_arb;
  localparam int P  = 2;
  localparam int N  = 4;
  localparam int PW = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_urgent;
  logic [N*PW-1:0]   req_payload;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [PW-1:0]     out_payload;
  logic [P-1:0]      out_src;
  logic              out_urgent;

  wb_arb #(.CONFIG_P_REQ(P), .CONFIG_PAYLOAD_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_urgent (req_urgent),
    .req_payload(req_payload),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(out_payload),
    .out_src    (out_src),
    .out_urgent (out_urgent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0]  src;
    logic [PW-1:0] pl;
    logic          urg;
  } exp_t;

  exp_t          q[$];
  int            total  = 0;
  int            passes = 0;
  int            seq    = 0;
  bit            pend   = 0;
  logic [PW-1:0] last_pl;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] u);
    seq++;
    req_valid  = v;
    req_urgent = u;
    for (int i = 0; i < N; i++)
      req_payload[i*PW +: PW] = {32'(seq), 32'(i), ~32'(seq), 32'hC0DE_0000 + 32'(i)};
    #1;
  endtask

  task automatic acc(input int i, input logic urg);
    exp_t e;
    logic [N-1:0] one;
    one = '0;
    one[i] = 1'b1;
    chk("req_ready", PW'(req_ready), PW'(one));
    e.src = P'(i);
    e.pl  = req_payload[i*PW +: PW];
    e.urg = urg;
    q.push_back(e);
    pend = 1;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (pend) begin
      e = q.pop_front();
      chk("out_valid", PW'(out_valid), PW'(1'b1));
      chk("out_src", PW'(out_src), PW'(e.src));
      chk("out_payload", out_payload, e.pl);
      chk("out_urgent", PW'(out_urgent), PW'(e.urg));
      last_pl = e.pl;
      pend = 0;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    req_valid = '0; req_urgent = '0; req_payload = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", PW'(out_valid), '0);
    chk("rst out_src", PW'(out_src), '0);
    chk("rst out_urgent", PW'(out_urgent), '0);
    chk("rst req_ready", PW'(req_ready), '0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Full rotation 0,1,2,3,0 back to back
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b0000); acc(i % N, 1'b0); step();
    end
    drive(4'b0000, 4'b0000);
    chk("idle req_ready", PW'(req_ready), '0);
    step();
    chk("drain out_valid", PW'(out_valid), '0);

    // Wrap: get ptr to 2, then 0011 grants 0 then 1
    drive(4'b0010, 4'b0000); acc(1, 1'b0); step();
    drive(4'b0011, 4'b0000); acc(0, 1'b0); step();
    drive(4'b0011, 4'b0000); acc(1, 1'b0); step();
    drive(4'b0000, 4'b0000); step();
    chk("drain2 out_valid", PW'(out_valid), '0);

    // Urgent class: ptr to 0, then urgent requester 2 jumps ahead
    drive(4'b1000, 4'b0000); acc(3, 1'b0); step();
    drive(4'b0000, 4'b0000); step();
    drive(4'b1111, 4'b0100); acc(2, 1'b1); step();
    drive(4'b1011, 4'b0000); acc(3, 1'b0); step();
    drive(4'b1011, 4'b0000); acc(0, 1'b0); step();
    drive(4'b1011, 4'b0000); acc(1, 1'b0); step();

    // Stall three cycles, then same-cycle drain and accept
    drive(4'b1111, 4'b0000); acc(2, 1'b0); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 4'b0000);
      chk("stall req_ready", PW'(req_ready), '0);
      step();
      chk("stall out_valid", PW'(out_valid), PW'(1'b1));
      chk("stall out_src", PW'(out_src), PW'(2));
      chk("stall out_payload", out_payload, last_pl);
    end
    out_ready = 1'b1;
    drive(4'b1111, 4'b0000);
    chk("no bubble out_valid", PW'(out_valid), PW'(1'b1));
    acc(3, 1'b0); step();

    // Flush kills an urgent held entry (src 1); ptr stays at 2
    drive(4'b1111, 4'b0000); acc(0, 1'b0); step();
    drive(4'b1111, 4'b0010); acc(1, 1'b1); step();
    flush = 1'b1; out_ready = 1'b0;
    drive(4'b1111, 4'b0000);
    chk("flush req_ready", PW'(req_ready), '0);
    step();
    chk("flush out_valid", PW'(out_valid), '0);
    chk("flush out_urgent", PW'(out_urgent), '0);
    flush = 1'b0; out_ready = 1'b1;
    drive(4'b1111, 4'b0000); acc(2, 1'b0); step();

    // Async reset between edges drops a stalled entry and rewinds ptr
    out_ready = 1'b0;
    drive(4'b1111, 4'b0000); step();
    chk("pre-rst out_valid", PW'(out_valid), PW'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", PW'(out_valid), '0);
    chk("async rst out_src", PW'(out_src), '0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    drive(4'b1111, 4'b0000); acc(0, 1'b0); step();

    chk("scoreboard empty", PW'(q.size()), '0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
